// File: rtl/redundancy_compactor.sv
// redundancy_compactor: packs kept lanes densely into 32-word lines with tail flush on in_last.
// Optional REDUNDANCY_COMPACTOR_STATS_EN adds saturating kept/dropped word counters.
module redundancy_compactor #(
  parameter int WORD_WIDTH = 8,
  parameter int PSUM_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [31:0]              in_mask,
  input  logic [32*PSUM_WIDTH-1:0] in_psum,
  input  logic [32*WORD_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*WORD_WIDTH-1:0] out_data,
  output logic [5:0]               out_count,
  output logic                     out_last
`ifdef REDUNDANCY_COMPACTOR_STATS_EN
  ,
  output logic [31:0]              stat_kept,
  output logic [31:0]              stat_dropped
`endif
);
  localparam int W = WORD_WIDTH;
  typedef enum logic {ACCEPT, TAIL} state_t;
  state_t state, state_next;
  logic [5:0] fill, cnt;
  logic [PSUM_WIDTH-1:0] psum_top;
  logic [6:0] total;
  logic [32*W-1:0] residual, line_d;
  logic [64*W-1:0] comb;
  logic [W-1:0] pk [32];
  logic slot_free, take, big, tail_load, load;
  assign slot_free = ~out_valid | out_ready;
  assign in_ready = ~reset & (state == ACCEPT) & slot_free;
  assign take = in_valid & in_ready;
  assign tail_load = (state == TAIL) & slot_free;
  assign psum_top = in_psum[31*PSUM_WIDTH+:PSUM_WIDTH];
  // Clamp a corrupt count so fill never exceeds the residual buffer.
  assign cnt = psum_top > PSUM_WIDTH'(32) ? 6'd32 : 6'(psum_top);
  assign total = {1'b0, fill} + {1'b0, cnt};
  assign big = total >= 7'd32;
  assign load = tail_load | (take & (big | in_last));
  assign line_d = tail_load ? residual : comb[0+:32*W];
  always_comb begin
    pk = '{default: '0};
    for (int i = 0; i < 32; i++)
      if (in_mask[i]) pk[5'(in_psum[i*PSUM_WIDTH+:PSUM_WIDTH] - PSUM_WIDTH'(1))] = in_data[i*W+:W];
  end
  // Residual words first, then this vector's packed words; slots past total stay zero.
  always_comb begin
    comb = '0;
    for (int j = 0; j < 64; j++)
      if (j < int'(fill)) comb[j*W+:W] = residual[(j%32)*W+:W];
      else if (j - int'(fill) < int'(cnt)) comb[j*W+:W] = pk[5'(j - int'(fill))];
  end
  always_comb begin
    state_next = state;
    if (tail_load) state_next = ACCEPT;
    else if (take & big & in_last & (total != 7'd32)) state_next = TAIL;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCEPT;
      fill      <= '0;
      residual  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= load | (out_valid & ~out_ready);
      if (load) out_data <= line_d;
      if (tail_load) begin
        out_count <= fill;
        out_last  <= 1'b1;
        fill      <= '0;
        residual  <= '0;
      end else if (take & big) begin
        out_count <= 6'd32;
        out_last  <= in_last & (total == 7'd32);
        fill      <= 6'(total - 7'd32);
        residual  <= comb[32*W+:32*W];
      end else if (take & in_last) begin
        out_count <= total[5:0];
        out_last  <= 1'b1;
        fill      <= '0;
        residual  <= '0;
      end else if (take) begin
        fill      <= total[5:0];
        residual  <= comb[0+:32*W];
      end
    end
  end
`ifdef REDUNDANCY_COMPACTOR_STATS_EN
  logic [32:0] kept_sum, drop_sum;
  assign kept_sum = {1'b0, stat_kept} + 33'(cnt);
  assign drop_sum = {1'b0, stat_dropped} + 33'(6'd32 - cnt);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_kept    <= '0;
      stat_dropped <= '0;
    end else if (take) begin
      stat_kept    <= kept_sum[32] ? '1 : kept_sum[31:0];
      stat_dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_redundancy_compactor.sv
// tb_redundancy_compactor: scoreboard bench with a word-queue reference model of the compactor.
module tb_redundancy_compactor;
  localparam int W = 8;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 1, out_last;
  logic [31:0] in_mask = 0;
  logic [191:0] in_psum = 0;
  logic [255:0] in_data = 0, out_data, snap;
  logic [5:0] out_count;
  typedef struct {logic [255:0] d; int c; bit l;} line_t;
  line_t expq[$];
  logic [7:0] mq[$];
  int cmp = 0, bad = 0, ready_mode = 0;

  redundancy_compactor #(.WORD_WIDTH(8), .PSUM_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mask(in_mask), .in_psum(in_psum), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_last(out_last));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] psum_of(input logic [31:0] m);
    int c = 0;
    psum_of = '0;
    for (int i = 0; i < 32; i++) begin
      c += int'(m[i]);
      psum_of[i*6+:6] = 6'(c);
    end
  endfunction

  function automatic logic [255:0] lanes(input logic [7:0] base);
    for (int i = 0; i < 32; i++) lanes[i*8+:8] = base + 8'(i);
  endfunction

  // Reference: a plain word stream cut into 32-word lines; in_last flushes the remainder.
  task automatic model(input logic [31:0] m, input logic [255:0] d, input bit l);
    line_t ln;
    int emitted = 0, n;
    for (int i = 0; i < 32; i++) if (m[i]) mq.push_back(d[i*8+:8]);
    while (mq.size() >= 32) begin
      ln.d = '0;
      for (int k = 0; k < 32; k++) ln.d[k*8+:8] = mq.pop_front();
      ln.c = 32;
      ln.l = l && mq.size() == 0;
      expq.push_back(ln);
      emitted++;
    end
    if (l && (mq.size() > 0 || emitted == 0)) begin
      n = mq.size();
      ln.d = '0;
      for (int k = 0; k < n; k++) ln.d[k*8+:8] = mq.pop_front();
      ln.c = n;
      ln.l = 1;
      expq.push_back(ln);
    end
  endtask

  task automatic send(input logic [31:0] m, input logic [255:0] d, input bit l);
    int n = 0;
    in_mask = m; in_psum = psum_of(m); in_data = d; in_last = l; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      cmp++; bad++;
      $display("FAIL accept_timeout: in_ready stuck 0, required 1");
    end else model(m, d, l);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom % 2) : 1'b0;
  end

  always @(negedge clk) begin
    line_t e;
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        cmp++; bad++;
        $display("FAIL unexpected_line: count %0d, required no line", out_count);
      end else begin
        e = expq.pop_front();
        chk("line_data", out_data, e.d);
        chk("line_count", 256'(out_count), 256'(e.c));
        chk("line_last", 256'(out_last), 256'(e.l));
      end
    end
  end

  initial begin
    logic [31:0] m;
    logic [255:0] d;
    int k;
    #1;
    chk("rst_out_valid", 256'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", 256'(out_count), 0);
    chk("rst_out_last", 256'(out_last), 0);
    chk("rst_in_ready", 256'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    send(32'hFFFFFFFF, lanes(0), 0);
    send(32'h0000FFFF, lanes(0), 0);
    @(negedge clk);
    chk("no_line_after_half", 256'(out_valid), 0);
    @(posedge clk); #1;
    send(32'h0000FFFF, lanes(8'h40), 0);
    send(32'h000FFFFF, lanes(0), 0);
    send(32'h000FFFFF, lanes(8'h20), 1);
    @(negedge clk);
    chk("tail_in_ready", 256'(in_ready), 0);
    @(posedge clk); #1;
    send(32'h0, lanes(8'h77), 1);
    ready_mode = 2;
    repeat (2) @(posedge clk); #1;
    send(32'hFFFFFFFF, lanes(8'h10), 0);
    in_mask = 32'hFFFFFFFF; in_psum = psum_of(in_mask); in_data = lanes(8'h20); in_last = 1; in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_data", out_data, lanes(8'h10));
      chk("stall_valid", 256'(out_valid), 1);
      chk("stall_in_ready", 256'(in_ready), 0);
    end
    ready_mode = 0;
    @(posedge clk); #1;
    send(32'hFFFFFFFF, lanes(8'h20), 1);
    send(32'h00000FFF, lanes(8'h50), 0);
    ready_mode = 2;
    repeat (2) @(posedge clk); #1;
    send(32'hFFFFFFFF, lanes(8'h60), 0);
    #3 reset = 1;
    #1;
    chk("async_rst_valid", 256'(out_valid), 0);
    chk("async_rst_in_ready", 256'(in_ready), 0);
    expq.delete();
    mq.delete();
    #2 reset = 0;
    ready_mode = 0;
    @(posedge clk); #1;
    send(32'hFFFFFFFF, lanes(8'h80), 1);
    ready_mode = 1;
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 3);
      m = k == 0 ? 32'hFFFFFFFF : k == 1 ? 32'h0 : k == 2 ? $urandom : (32'h1 << $urandom_range(0, 31)) - 1;
      for (int i = 0; i < 32; i++) d[i*8+:8] = 8'($urandom);
      send(m, d, $urandom_range(0, 5) == 0);
    end
    send(32'h0000FFFF, lanes(8'h90), 1);
    ready_mode = 0;
    k = 0;
    while (expq.size() > 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    cmp++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d lines outstanding, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/redundancy_compactor.md
Name: redundancy_compactor

Overview:
- Consumes the 32-lane keep-mask and the inclusive per-lane prefix counts produced by the prefix-sum stage, together with the 32-lane data vector.
- Packs the kept words densely, preserving ascending lane order, into a 32-word residual buffer.
- Emits full 32-word lines downstream on a valid/ready handshake; a last-marked input flushes any partial tail line.
- Sits directly downstream of the 32-lane prefix adder and feeds the packed-line writer.

Parameters:
WORD_WIDTH, 8, bit width of one data word/lane
PSUM_WIDTH, 6, width of one per-lane prefix count (fixed for 32 lanes; must be 6)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input vector valid
in_ready  output  1  block accepts vector this cycle
in_last  input  1  final vector of a stream; flush after absorbing it
in_mask  input  32  1 = keep lane i
in_psum  input  32*PSUM_WIDTH  lane i count at [i*6+:6]; inclusive prefix count of in_mask[0..i]
in_data  input  32*WORD_WIDTH  lane i word at [i*WORD_WIDTH+:WORD_WIDTH]
out_valid  output  1  output line valid
out_ready  input  1  downstream accepts line
out_data  output  32*WORD_WIDTH  packed line, slot 0 = oldest word
out_count  output  6  valid words in line, 0..32
out_last  output  1  line closes the stream

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values: out_valid=0, out_data=0, out_count=0, out_last=0, fill=0, residual=0, state=ACCEPT. in_ready=0 while reset is high.
- Input handshake:
  - Accept when in_valid & in_ready.
  - in_ready = (state==ACCEPT) & (~out_valid | out_ready).
  - Inputs are sampled only on accept.
- Packing:
  - Lane i with in_mask[i]=1 goes to packed index in_psum[i]-1.
  - count = in_psum[31] (0..32).
  - The psum is trusted and not recomputed; inconsistent psum/mask gives an undefined result with no hang.
- Merge: combined stream = residual[0..fill-1] followed by packed[0..count-1]; total = fill+count (0..63, 7-bit arithmetic).
- ACCEPT state, on accept:
  - total>=32: load output register with combined[0..31], out_count=32; residual = combined[32..total-1], shifted to slot 0; fill=total-32.
    - If in_last and fill_new>0: out_last=0, go to TAIL.
    - If in_last and fill_new==0: out_last=1.
  - total<32, in_last=0: no output; fill=total.
  - total<32, in_last=1: load output with combined[0..total-1], zero the upper slots; out_count=total (0 allowed = empty terminator); out_last=1; fill=0.
- TAIL state:
  - in_ready=0.
  - When the output slot is free (~out_valid | out_ready): load residual as the line, out_count=fill, out_last=1, fill=0, return to ACCEPT.
- Output register:
  - out_valid rises the cycle after the accept or TAIL load (1-cycle latency).
  - out_data, out_count and out_last are held stable while out_valid & ~out_ready.
  - Drain and reload in the same cycle are allowed (full throughput, one vector per cycle).
  - out_valid drops after a handshake when no new load occurs.
- Unused output slots are always zero.
- Residual slots at index >= fill are zero.
- Asserting reset mid-stream discards the residual and any pending line immediately.

Optional Feature:
- Macro: REDUNDANCY_COMPACTOR_STATS_EN.
- When defined, adds two 32-bit saturating output counters:
  - stat_kept: sum of count over accepted vectors.
  - stat_dropped: sum of (32-count) over accepted vectors.
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, neither the ports nor the logic exist.

Test Plan:
- Mask 0xFFFFFFFF, psum[i]=i+1, data lane i=i, in_last=0, out_ready=1 -> next cycle out_valid=1, out_data slot i=i, out_count=32, out_last=0, fill=0.
- Two vectors, mask 0x0000FFFF, data A lane i=i, then B lane i=0x40+i -> no output after A. After B: slots 0..15=0..15, slots 16..31=0x40..0x4F, count=32.
- Mask 0x000FFFFF (count 20) twice, second with in_last=1:
  - Line 1: count=32, last=0; in_ready=0 for one cycle (TAIL).
  - Line 2: count=8, slots 0..7 = lanes 12..19 of vector 2, slots 8..31=0, last=1.
- out_ready held low 5 cycles with out_valid=1 and in_valid=1 -> out_data stable, in_ready=0. After release, every vector is delivered exactly once, in order.
- in_last with mask 0 and fill=0 -> one line with out_count=0, out_data=0, out_last=1.
- Reset pulse asynchronous to clk with fill=12 and out_valid=1 -> out_valid=0 immediately. After release, a mask 0xFFFFFFFF vector yields a line with no stale words.
